cp0_irq_sequencer: RTL and testbench

//  Coprocessor-0 exception/interrupt sequencer for the 5-stage MIPS pipeline.
//  - Owns the IE and EPC registers and latches pending interrupt requests.
//  - Arbitrates between syscall and NUM_IRQ interrupt lines.
//  - Sequences pipeline flush and the PC redirect into a handler; eret returns to EPC.
//  - IE_value, EPC_value feed the decode-stage controller's CPR read mux; mtc0, eret, syscall come back from it.

---
 rtl/cp0_irq_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cp0_irq_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_irq_sequencer.sv
// Coprocessor-0 exception/interrupt sequencer: owns IE/EPC, latches pending irqs,
// and walks take -> flush -> redirect -> service -> eret return.
module cp0_irq_sequencer #(
    parameter int unsigned NUM_IRQ      = 3,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0400,
    parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               commit_valid,
    input  logic [31:0]        pc_resume,
    input  logic               syscall,
    input  logic               eret,
    input  logic               mtc0,
    input  logic               cpr0_sel,
    input  logic [31:0]        mtc0_data,
    output logic [31:0]        IE_value,
    output logic [31:0]        EPC_value,
    output logic               flush,
    output logic               pc_redirect,
    output logic [31:0]        redirect_pc,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [3:0]         cause
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT,
        ST_SERVICE,
        ST_RETURN
    } state_t;

    localparam logic [3:0] CAUSE_SYSCALL = 4'hF;

    state_t             state_q, state_d;
    logic [31:0]        ie_q, ie_d;
    logic [31:0]        epc_q, epc_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [3:0]         cause_q, cause_d;
    logic [2:0]         cnt_q, cnt_d;

    logic [NUM_IRQ-1:0] eligible;
    logic               any_eligible;
    logic [3:0]         elig_idx;
    logic [NUM_IRQ-1:0] ack_w;
    logic [31:0]        vec_idx;
    logic [31:0]        vec_addr;
    logic               mtc0_we;
    logic               take;

    assign eligible = pend_q & ie_q[NUM_IRQ:1] & {NUM_IRQ{ie_q[0]}};
    assign mtc0_we  = commit_valid & mtc0;
    assign take     = commit_valid & (syscall | any_eligible);

    // Scan from the top down so the lowest eligible index is the one left standing.
    always_comb begin
        elig_idx     = '0;
        any_eligible = 1'b0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (eligible[i-1]) begin
                elig_idx     = 4'(i - 1);
                any_eligible = 1'b1;
            end
        end
    end

    assign vec_idx  = (cause_q == CAUSE_SYSCALL) ? 32'(NUM_IRQ) : {28'b0, cause_q};
    assign vec_addr = HANDLER_BASE + vec_idx * VEC_STRIDE;

    always_comb begin
        ack_w = '0;
        if (state_q == ST_REDIRECT) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (cause_q == 4'(i)) ack_w[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        pend_d  = (pend_q & ~ack_w) | irq_req;

        case (state_q)
            ST_IDLE: begin
                // A take flushes the committing instruction, so its mtc0 is dropped.
                if (take) begin
                    epc_d   = pc_resume;
                    ie_d[0] = 1'b0;
                    cause_d = syscall ? CAUSE_SYSCALL : elig_idx;
                    cnt_d   = '0;
                    state_d = ST_FLUSH;
                end else if (mtc0_we) begin
                    if (cpr0_sel) epc_d = mtc0_data;
                    else          ie_d  = mtc0_data;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 3'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (mtc0_we) begin
                    if (cpr0_sel) epc_d = mtc0_data;
                    else          ie_d  = mtc0_data;
                end
                if (commit_valid && eret) state_d = ST_RETURN;
            end
            ST_RETURN: begin
                ie_d[0] = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ie_q    <= '0;
            epc_q   <= '0;
            pend_q  <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IE_value    = ie_q;
    assign EPC_value   = epc_q;
    assign flush       = (state_q == ST_FLUSH) || (state_q == ST_RETURN);
    assign pc_redirect = (state_q == ST_REDIRECT) || (state_q == ST_RETURN);
    assign redirect_pc = (state_q == ST_REDIRECT) ? vec_addr :
                         (state_q == ST_RETURN)   ? epc_q    : '0;
    assign in_service  = (state_q == ST_SERVICE);
    assign irq_ack     = ack_w;
    assign cause       = cause_q;

endmodule

// File: tb/tb_cp0_irq_sequencer.sv
// Bench for cp0_irq_sequencer: per-cycle vector table with a scoreboard queue,
// followed by a hand-driven asynchronous reset in the middle of a flush.
module tb_cp0_irq_sequencer;

    logic        clk;
    logic        rst_n;
    logic [2:0]  irq_req;
    logic        commit_valid;
    logic [31:0] pc_resume;
    logic        syscall;
    logic        eret;
    logic        mtc0;
    logic        cpr0_sel;
    logic [31:0] mtc0_data;
    logic [31:0] IE_value;
    logic [31:0] EPC_value;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        in_service;
    logic [2:0]  irq_ack;
    logic [3:0]  cause;

    cp0_irq_sequencer #(
        .NUM_IRQ     (3),
        .HANDLER_BASE(32'h0000_0400),
        .VEC_STRIDE  (32'h0000_0010),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_req     (irq_req),
        .commit_valid(commit_valid),
        .pc_resume   (pc_resume),
        .syscall     (syscall),
        .eret        (eret),
        .mtc0        (mtc0),
        .cpr0_sel    (cpr0_sel),
        .mtc0_data   (mtc0_data),
        .IE_value    (IE_value),
        .EPC_value   (EPC_value),
        .flush       (flush),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .in_service  (in_service),
        .irq_ack     (irq_ack),
        .cause       (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  irq;
        logic        cv;
        logic [31:0] pc;
        logic        sc;
        logic        er;
        logic        mt;
        logic        sel;
        logic [31:0] dat;
        logic        e_fl;
        logic        e_rd;
        logic [31:0] e_rpc;
        logic        e_sv;
        logic [2:0]  e_ack;
        logic [3:0]  e_cause;
        logic [31:0] e_ie;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic [2:0] irq, logic cv, logic [31:0] pc, logic sc,
                                logic er, logic mt, logic sel, logic [31:0] dat,
                                logic fl, logic rd, logic [31:0] rpc, logic sv,
                                logic [2:0] ack, logic [3:0] cs, logic [31:0] ie,
                                logic [31:0] epc);
        vec_t v;
        v.irq = irq; v.cv = cv; v.pc = pc; v.sc = sc; v.er = er; v.mt = mt;
        v.sel = sel; v.dat = dat; v.e_fl = fl; v.e_rd = rd; v.e_rpc = rpc;
        v.e_sv = sv; v.e_ack = ack; v.e_cause = cs; v.e_ie = ie; v.e_epc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        irq_req = '0; commit_valid = 1'b0; pc_resume = '0; syscall = 1'b0;
        eret = 1'b0; mtc0 = 1'b0; cpr0_sel = 1'b0; mtc0_data = '0;
    endtask

    initial begin
        vec_t v;
        vec_t e;
        rst_n = 1'b0;
        drive_idle();

        //       irq cv pc       sc er mt sel dat      fl rd rpc      sv ack cs  ie   epc
        vecs.push_back(mk(0, 1, 0,       0, 0, 1, 0, 'hF,   0, 0, 0,       0, 0, 0,  'h0, 'h0));
        vecs.push_back(mk(6, 1, 'h100,   0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 0,  'hF, 'h0));
        vecs.push_back(mk(0, 1, 'h100,   0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 0,  'hF, 'h0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 1,  'hE, 'h100));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 1,  'hE, 'h100));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 1, 'h410,   0, 2, 1,  'hE, 'h100));
        vecs.push_back(mk(1, 1, 0,       0, 0, 0, 0, 0,     0, 0, 0,       1, 0, 1,  'hE, 'h100));
        vecs.push_back(mk(0, 1, 0,       0, 0, 0, 0, 0,     0, 0, 0,       1, 0, 1,  'hE, 'h100));
        vecs.push_back(mk(0, 1, 0,       0, 1, 0, 0, 0,     0, 0, 0,       1, 0, 1,  'hE, 'h100));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 1, 'h100,   0, 0, 1,  'hE, 'h100));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 1,  'hF, 'h100));
        vecs.push_back(mk(0, 1, 'h200,   0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 1,  'hF, 'h100));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 0,  'hE, 'h200));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 0,  'hE, 'h200));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 1, 'h400,   0, 1, 0,  'hE, 'h200));
        vecs.push_back(mk(0, 1, 0,       0, 0, 1, 1, 'h300, 0, 0, 0,       1, 0, 0,  'hE, 'h200));
        vecs.push_back(mk(0, 0, 0,       0, 1, 0, 0, 0,     0, 0, 0,       1, 0, 0,  'hE, 'h300));
        vecs.push_back(mk(0, 1, 0,       0, 1, 0, 0, 0,     0, 0, 0,       1, 0, 0,  'hE, 'h300));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 1, 'h300,   0, 0, 0,  'hE, 'h300));
        vecs.push_back(mk(0, 1, 'h500,   0, 0, 1, 0, 0,     0, 0, 0,       0, 0, 0,  'hF, 'h300));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 2,  'hE, 'h500));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 2,  'hE, 'h500));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 1, 'h420,   0, 4, 2,  'hE, 'h500));
        vecs.push_back(mk(0, 1, 0,       0, 1, 0, 0, 0,     0, 0, 0,       1, 0, 2,  'hE, 'h500));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 1, 'h500,   0, 0, 2,  'hE, 'h500));
        vecs.push_back(mk(1, 1, 0,       0, 1, 0, 0, 0,     0, 0, 0,       0, 0, 2,  'hF, 'h500));
        vecs.push_back(mk(0, 1, 'h600,   1, 0, 0, 0, 0,     0, 0, 0,       0, 0, 2,  'hF, 'h500));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 15, 'hE, 'h600));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 15, 'hE, 'h600));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 1, 'h430,   0, 0, 15, 'hE, 'h600));
        vecs.push_back(mk(0, 1, 0,       0, 1, 0, 0, 0,     0, 0, 0,       1, 0, 15, 'hE, 'h600));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 1, 'h600,   0, 0, 15, 'hE, 'h600));
        vecs.push_back(mk(0, 1, 'h700,   0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 15, 'hF, 'h600));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 0,  'hE, 'h700));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 0,  'hE, 'h700));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 1, 'h400,   0, 1, 0,  'hE, 'h700));
        vecs.push_back(mk(0, 1, 0,       0, 0, 1, 0, 'h1,   0, 0, 0,       1, 0, 0,  'hE, 'h700));
        vecs.push_back(mk(7, 1, 0,       0, 1, 0, 0, 0,     0, 0, 0,       1, 0, 0,  'h1, 'h700));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 1, 'h700,   0, 0, 0,  'h1, 'h700));
        vecs.push_back(mk(0, 1, 0,       0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 0,  'h1, 'h700));
        vecs.push_back(mk(0, 1, 0,       0, 0, 1, 0, 'h3,   0, 0, 0,       0, 0, 0,  'h1, 'h700));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 0,  'h3, 'h700));
        vecs.push_back(mk(0, 1, 'h800,   0, 0, 0, 0, 0,     0, 0, 0,       0, 0, 0,  'h3, 'h700));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 0,  'h2, 'h800));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 0,       0, 0, 0,  'h2, 'h800));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 1, 'h400,   0, 1, 0,  'h2, 'h800));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,     0, 0, 0,       1, 0, 0,  'h2, 'h800));

        #3;
        chk("reset_flush", {31'b0, flush}, 32'h0);
        chk("reset_redirect", {31'b0, pc_redirect}, 32'h0);
        chk("reset_ie", IE_value, 32'h0);
        chk("reset_epc", EPC_value, 32'h0);
        chk("reset_cause", {28'b0, cause}, 32'h0);
        chk("reset_ack", {29'b0, irq_ack}, 32'h0);
        #9 rst_n = 1'b1;

        for (int unsigned k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            v = vecs[k];
            irq_req = v.irq; commit_valid = v.cv; pc_resume = v.pc; syscall = v.sc;
            eret = v.er; mtc0 = v.mt; cpr0_sel = v.sel; mtc0_data = v.dat;
            sb.push_back(v);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk($sformatf("r%0d_scoreboard_empty", k), 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("r%0d_flush", k), {31'b0, flush}, {31'b0, e.e_fl});
                chk($sformatf("r%0d_pc_redirect", k), {31'b0, pc_redirect}, {31'b0, e.e_rd});
                chk($sformatf("r%0d_redirect_pc", k), redirect_pc, e.e_rpc);
                chk($sformatf("r%0d_in_service", k), {31'b0, in_service}, {31'b0, e.e_sv});
                chk($sformatf("r%0d_irq_ack", k), {29'b0, irq_ack}, {29'b0, e.e_ack});
                chk($sformatf("r%0d_cause", k), {28'b0, cause}, {28'b0, e.e_cause});
                chk($sformatf("r%0d_ie", k), IE_value, e.e_ie);
                chk($sformatf("r%0d_epc", k), EPC_value, e.e_epc);
            end
        end

        // Return to IDLE, re-enable line 1 and take it, then reset mid-flush.
        @(posedge clk); #1; drive_idle(); eret = 1'b1; commit_valid = 1'b1;
        @(posedge clk); #1; drive_idle();
        @(posedge clk); #1; drive_idle(); mtc0 = 1'b1; mtc0_data = 32'hF; commit_valid = 1'b1;
        @(posedge clk); #1; drive_idle(); commit_valid = 1'b1; pc_resume = 32'h900;
        @(posedge clk); #1; drive_idle();
        chk("midflush_flush", {31'b0, flush}, 32'h1);
        chk("midflush_cause", {28'b0, cause}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flush", {31'b0, flush}, 32'h0);
        chk("async_rst_redirect", {31'b0, pc_redirect}, 32'h0);
        chk("async_rst_ie", IE_value, 32'h0);
        chk("async_rst_epc", EPC_value, 32'h0);
        chk("async_rst_cause", {28'b0, cause}, 32'h0);
        chk("async_rst_service", {31'b0, in_service}, 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Pending line 2 must have been wiped: enabling everything must not cause a take.
        @(posedge clk); #1; drive_idle(); mtc0 = 1'b1; mtc0_data = 32'hF; commit_valid = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            @(posedge clk); #1; drive_idle(); commit_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("post_rst_no_take_%0d", c), {31'b0, flush}, 32'h0);
        end
        chk("post_rst_ie", IE_value, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
